// File: rtl/lanzones_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lanzones_mem_pkg
// Brief   : Shared encodings for the lanzones memory master (sizes, states).
// Rev     : 1.0  initial release
// ============================================================================
package lanzones_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int         STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RD   = 2'd1;
    localparam logic [STATE_W-1:0] WR   = 2'd2;
    localparam logic [STATE_W-1:0] RESP = 2'd3;

    localparam int DEF_ADDR_SHIFT = 2;

    // Size 3 is always illegal; halves need even, words need 4-aligned addresses.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = (lane != 2'd0);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lanzones_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : lanzones_lane_align
// Brief   : Combinational load extract/extend and store lane merge.
// Rev     : 1.0  initial release
// ============================================================================
module lanzones_lane_align
    import lanzones_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_is_unsigned,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_shift;
    logic [31:0] w_sh;
    logic [31:0] w_mask;

    always_comb begin
        w_shift = {i_lane, 3'b000};
        w_sh    = i_rword >> w_shift;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = i_is_unsigned ? {24'h0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
                w_mask      = 32'h0000_00FF << w_shift;
            end
            SZ_HALF: begin
                o_load_data = i_is_unsigned ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
                w_mask      = 32'h0000_FFFF << w_shift;
            end
            default: begin
                o_load_data = w_sh;
                w_mask      = 32'hFFFF_FFFF;
            end
        endcase
        // Store data arrives right-aligned; move it into its lane over the old word.
        o_merge_data = (i_rword & ~w_mask) | ((i_wdata << w_shift) & w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/lanzones_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : lanzones_mem_master
// Brief   : Core load/store to word-only lanzones bus initiator with RMW.
//           Optional bus timeout: LANZONES_MEM_MASTER_TIMEOUT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module lanzones_mem_master
    import lanzones_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_SHIFT     = DEF_ADDR_SHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_vld,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        RRdy,
    input  logic        RVld,
    output logic [31:0] RAddr,
    output logic [31:0] RWData,
    output logic        RWEn,
    input  logic [31:0] RData
);

    logic [STATE_W-1:0] r_state, w_ns;
    logic        r_we, r_uns;
    logic [1:0]  r_size, r_lane;
    logic [31:0] r_wdata;
    logic        r_req_rdy, r_rsp_vld, r_rsp_err, r_rrdy, r_rwen;
    logic [31:0] r_rsp_rdata, r_raddr, r_rwdata;

    logic        w_accept, w_misalign, w_done, w_tmo;
    logic        w_req_rdy_d, w_rrdy_d, w_rwen_d, w_rsp_vld_d, w_rsp_err_d;
    logic [31:0] w_rsp_rdata_d, w_raddr_d, w_rwdata_d;
    logic [31:0] w_load, w_merge;

    assign w_accept   = req_vld && r_req_rdy;
    assign w_misalign = misaligned(req_size, req_addr[1:0]);
    // RVld only counts while a request is actually on the bus.
    assign w_done     = RVld && r_rrdy;

    lanzones_lane_align u_align (
        .i_size        (r_size),
        .i_lane        (r_lane),
        .i_is_unsigned (r_uns),
        .i_rword       (RData),
        .i_wdata       (r_wdata),
        .o_load_data   (w_load),
        .o_merge_data  (w_merge)
    );

`ifdef LANZONES_MEM_MASTER_TIMEOUT_EN
    localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               w_waiting;

    assign w_waiting = (r_state == RD) || ((r_state == WR) && r_rrdy);
    assign w_tmo     = w_waiting && !RVld && (r_tmo_cnt == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tmo_cnt <= '0;
        else if (!w_waiting || (w_ns != r_state))
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
`else
    assign w_tmo = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= SZ_BYTE;
            r_lane      <= 2'd0;
            r_wdata     <= 32'h0;
            r_req_rdy   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rrdy      <= 1'b0;
            r_rwen      <= 1'b0;
            r_raddr     <= 32'h0;
            r_rwdata    <= 32'h0;
        end else begin
            r_state     <= w_ns;
            if (w_accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_lane  <= req_addr[1:0];
                r_wdata <= req_wdata;
            end
            r_req_rdy   <= w_req_rdy_d;
            r_rsp_vld   <= w_rsp_vld_d;
            r_rsp_err   <= w_rsp_err_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_rrdy      <= w_rrdy_d;
            r_rwen      <= w_rwen_d;
            r_raddr     <= w_raddr_d;
            r_rwdata    <= w_rwdata_d;
        end
    end

    always_comb begin
        w_ns = r_state;
        case (r_state)
            IDLE: if (w_accept) begin
                if (w_misalign)                          w_ns = RESP;
                else if (req_we && (req_size == SZ_WORD)) w_ns = WR;
                else                                     w_ns = RD;
            end
            RD:   if (w_done)     w_ns = r_we ? WR : RESP;
                  else if (w_tmo) w_ns = RESP;
            WR:   if (w_done || w_tmo) w_ns = RESP;
            RESP: w_ns = IDLE;
            default: w_ns = IDLE;
        endcase
    end

    // Next values of the registered outputs. An RD->WR hop lets RRdy fall for a
    // cycle so it is never held across two RVld pulses; the write starts after.
    always_comb begin
        w_req_rdy_d   = (w_ns == IDLE);
        w_rrdy_d      = (w_ns == RD) || ((w_ns == WR) && (r_state != RD));
        w_rwen_d      = w_rrdy_d && (w_ns == WR) && !((r_state == WR) && r_rrdy);
        w_rsp_vld_d   = (w_ns == RESP);
        w_rsp_err_d   = (w_ns == RESP) && ((r_state == IDLE) || w_tmo);
        w_rsp_rdata_d = ((r_state == RD) && w_done && !r_we) ? w_load : 32'h0;
        w_raddr_d     = r_raddr;
        w_rwdata_d    = r_rwdata;
        if (w_accept && !w_misalign) begin
            w_raddr_d = req_addr >> ADDR_SHIFT;
            if (req_we && (req_size == SZ_WORD))
                w_rwdata_d = req_wdata;
        end else if ((r_state == RD) && w_done && r_we) begin
            w_rwdata_d = w_merge;
        end
    end

    assign req_rdy   = r_req_rdy;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign RRdy      = r_rrdy;
    assign RWEn      = r_rwen;
    assign RAddr     = r_raddr;
    assign RWData    = r_rwdata;

endmodule
`default_nettype wire

// File: tb/tb_lanzones_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_lanzones_mem_master
// Brief   : Directed self-checking bench with a zero-wait memory responder.
// Rev     : 1.0  initial release
// ============================================================================
module tb_lanzones_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_rdy, rsp_vld, rsp_err, RRdy, RWEn, RVld;
    logic [31:0] rsp_rdata, RAddr, RWData;
    logic [31:0] RData;

    logic        rvld_auto, rvld_man = 1'b0, resp_en = 1'b1;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;
    logic [31:0] mem [0:63];
    logic [31:0] last_wdata;
    int n_txn = 0, n_wen = 0, n_rrdy_cyc = 0;
    int n_pass = 0, n_fail = 0, n_total = 0;

    assign RVld = rvld_auto | rvld_man;

    always #5 clk = ~clk;

    lanzones_mem_master dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .RRdy(RRdy), .RVld(RVld), .RAddr(RAddr), .RWData(RWData), .RWEn(RWEn), .RData(RData)
    );

    // Responder: one-cycle RVld pulse the cycle after it first sees RRdy.
    always @(posedge clk) begin
        if (rst) begin
            rvld_auto <= 1'b0;
            RData     <= 32'h0;
        end else begin
            if (pl_en) mem[pl_idx] <= pl_val;
            rvld_auto <= 1'b0;
            if (RRdy) n_rrdy_cyc <= n_rrdy_cyc + 1;
            if (RWEn) begin
                n_wen      <= n_wen + 1;
                last_wdata <= RWData;
            end
            if (RRdy && !RVld && resp_en) begin
                rvld_auto <= 1'b1;
                n_txn     <= n_txn + 1;
                RData     <= mem[RAddr[5:0]];
                if (RWEn) mem[RAddr[5:0]] <= RWData;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output logic ok);
        for (int i = 0; i < 20; i++) begin
            if (req_rdy) break;
            tick();
        end
        req_vld = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        tick();
        req_vld = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_vld) break;
            tick();
        end
        ok = rsp_vld; rd = rsp_rdata; er = rsp_err;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er, ok, seen;
        int          snap_a, snap_b;

        // Reset state
        tick();
        chk("rst_req_rdy", {31'h0, req_rdy}, 32'h0);
        chk("rst_outs", {26'h0, rsp_vld, rsp_err, RRdy, RWEn, 2'b00}, 32'h0);
        chk("rst_raddr", RAddr, 32'h0);
        chk("rst_rwdata", RWData, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_req_rdy", {31'h0, req_rdy}, 32'h1);

        // Word load, cycle-accurate
        preload(6'd4, 32'hDEADBEEF);
        req_vld = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        tick();
        req_vld = 1'b0;
        chk("wl_c1_rrdy", {31'h0, RRdy}, 32'h1);
        chk("wl_c1_raddr", RAddr, 32'h4);
        chk("wl_c1_req_rdy", {31'h0, req_rdy}, 32'h0);
        tick();
        chk("wl_c2_rrdy", {31'h0, RRdy}, 32'h1);
        chk("wl_c2_rsp_vld", {31'h0, rsp_vld}, 32'h0);
        tick();
        chk("wl_c3_rsp_vld", {31'h0, rsp_vld}, 32'h1);
        chk("wl_c3_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("wl_c3_err", {31'h0, rsp_err}, 32'h0);
        chk("wl_c3_rrdy", {31'h0, RRdy}, 32'h0);
        tick();
        chk("wl_c4_rsp_vld", {31'h0, rsp_vld}, 32'h0);
        chk("wl_c4_req_rdy", {31'h0, req_rdy}, 32'h1);

        // Sub-word loads
        preload(6'd4, 32'h80112233);
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, ok);
        chk("lb_signed", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, ok);
        chk("lb_unsigned", rd, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, ok);
        chk("lh_signed", rd, 32'hFFFF8011);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, er, ok);
        chk("lb_lane1", rd, 32'h00000022);

        // Half store: read, merge, single write
        preload(6'd8, 32'h11223344);
        snap_a = n_txn; snap_b = n_wen;
        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, rd, er, ok);
        chk("sh_ok", {31'h0, ok}, 32'h1);
        chk("sh_err", {31'h0, er}, 32'h0);
        chk("sh_rdata", rd, 32'h0);
        chk("sh_txns", n_txn - snap_a, 32'd2);
        chk("sh_wen_cycles", n_wen - snap_b, 32'd1);
        chk("sh_rwdata", last_wdata, 32'hABCD3344);
        chk("sh_mem", mem[8], 32'hABCD3344);

        // Word store then byte store
        snap_a = n_txn;
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, rd, er, ok);
        chk("sw_txns", n_txn - snap_a, 32'd1);
        chk("sw_mem", mem[8], 32'h12345678);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF5A, rd, er, ok);
        chk("sb_mem", mem[8], 32'h12345A78);

        // Misaligned / illegal: error response without bus activity
        snap_a = n_rrdy_cyc;
        do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, er, ok);
        chk("mis_w_ok", {31'h0, ok}, 32'h1);
        chk("mis_w_err", {31'h0, er}, 32'h1);
        chk("mis_w_rdata", rd, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h0, rd, er, ok);
        chk("mis_h_err", {31'h0, er}, 32'h1);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd, er, ok);
        chk("size3_err", {31'h0, er}, 32'h1);
        chk("mis_no_rrdy", n_rrdy_cyc - snap_a, 32'd0);
        chk("mis_mem_kept", mem[8], 32'h12345A78);

        // Reset in the middle of a read
        resp_en = 1'b0;
        req_vld = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        tick();
        req_vld = 1'b0;
        tick();
        chk("mid_rrdy", {31'h0, RRdy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {26'h0, req_rdy, rsp_vld, rsp_err, RRdy, RWEn, 1'b0}, 32'h0);
        chk("mid_rst_raddr", RAddr, 32'h0);
        tick();
        rst = 1'b0;
        rvld_man = 1'b1;
        tick();
        rvld_man = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | rsp_vld;
            tick();
        end
        chk("mid_no_rsp", {31'h0, seen}, 32'h0);
        resp_en = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, ok);
        chk("post_rst_ok", {31'h0, ok}, 32'h1);
        chk("post_rst_rdata", rd, 32'h80112233);

`ifdef LANZONES_MEM_MASTER_TIMEOUT_EN
        resp_en = 1'b0;
        snap_a = n_rrdy_cyc;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, ok);
        chk("tmo_ok", {31'h0, ok}, 32'h1);
        chk("tmo_err", {31'h0, er}, 32'h1);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_rrdy_cycles", n_rrdy_cyc - snap_a, 32'd64);
        chk("tmo_rrdy_low", {31'h0, RRdy}, 32'h0);
        resp_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lanzones_mem_master.md
Name: lanzones_mem_master

Overview:
- Initiator end of the lanzones memory request interface (RRdy/RVld/RAddr/RWData/RWEn/RData); the counterpart of the testbench memory responder.
- Accepts one load or store at a time from the core over a valid/ready port.
- Sequences the word-only bus, using read-modify-write for sub-word stores.
- Returns extended load data, or an error, on a one-cycle response strobe.

Parameters:
- TIMEOUT_CYCLES, 64: bus cycles to wait for RVld before aborting. Used only with the optional feature.
- ADDR_SHIFT, 2: right shift from core byte address to bus word address.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_vld  in  1  core request valid
- req_rdy  out  1  high only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_vld  out  1  one-cycle completion strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_vld
- RRdy  out  1  bus request
- RVld  in  1  responder completion pulse
- RAddr  out  32  word address, req_addr >> ADDR_SHIFT
- RWData  out  32  full write word
- RWEn  out  1  write strobe
- RData  in  32  read word, valid while RVld=1

Behaviour:
- Reset values: req_rdy=0 while rst asserted, 1 in IDLE after release. All of rsp_vld, rsp_rdata, rsp_err, RRdy, RWEn, RAddr, RWData are 0.
- Reset asserted mid-operation aborts the access and returns to IDLE with no response and no write.
- All outputs are registered.
- States:
  - IDLE: request accepted on an edge where req_vld && req_rdy; address, size, data and flags are latched.
  - RD: RRdy=1, waiting for RVld.
  - WR: RRdy=1, waiting for RVld; RWEn=1 only on the first cycle of WR.
  - RESP: rsp_vld=1 for one cycle, then IDLE.
- Alignment check at accept:
  - size=1 with addr[0]=1, size=2 with addr[1:0]!=0, or size=3 → RESP with rsp_err=1.
  - No bus activity in the error case.
- Load: IDLE→RD. On the edge where RVld=1:
  - capture RData, shift right by 8*addr[1:0];
  - extend from 8/16 bits, or pass 32 bits;
  - clear RRdy; go to RESP.
  - Timing: accept edge in cycle 0, RRdy high in cycles 1–2, rsp_vld in cycle 3 for a zero-wait responder.
- Word store: IDLE→WR with RWData=req_wdata. On RVld → RESP.
- Sub-word store: IDLE→RD, then merge the byte/half into the captured word at lane addr[1:0]. Then WR with the merged RWData, then RESP.
- RRdy always drops on the edge that samples RVld=1. RRdy is never held across two RVld pulses.
- RVld while in IDLE or RESP is ignored.
- RAddr and RWData stay stable while RRdy=1.
- Address arithmetic is modulo 2^32; no wrap check.

Optional Feature:
- Macro: LANZONES_MEM_MASTER_TIMEOUT_EN.
- When defined: a counter runs in RD/WR, cleared on entry. After TIMEOUT_CYCLES cycles without RVld: drop RRdy/RWEn, go to RESP with rsp_err=1, rsp_rdata=0.
- When undefined: wait indefinitely; the counter logic is absent.

Decomposition:
- Package lanzones_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding IDLE/RD/WR/RESP;
  - ADDR_SHIFT default.
- Sub-module lanzones_lane_align (combinational): load extract/extend and store merge by size and addr[1:0]. Shared by both paths.

Test Plan:
- Word load, addr 0x10, mem[4]=0xDEADBEEF → RAddr=4, RRdy in cycles 1–2, rsp_vld cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Signed byte load, addr 0x13, mem[4]=0x80112233 → rsp_rdata=0xFFFFFF80. The same access with req_unsigned=1 → 0x00000080.
- Half store 0xABCD to addr 0x22, mem[8]=0x11223344 → one read, then one RWEn cycle with RWData=0xABCD3344; mem[8]=0xABCD3344 afterwards.
- Word load at addr 0x6 → rsp_vld with rsp_err=1, RRdy never asserted.
- Reset asserted while in RD → all outputs 0 immediately; a later RVld produces no rsp_vld; the next request completes normally.
- With LANZONES_MEM_MASTER_TIMEOUT_EN and a responder that never asserts RVld → after 64 cycles RRdy=0, rsp_vld=1, rsp_err=1.
